step_interval_timer: RTL
========================

// Module: step_interval_timer
// PURPOSE
//   Multi-channel programmable interval timer; parametrised successor to the single-channel
//   count-to-max counter in the step-motor controller. Each channel emits a one-cycle tick every
//   (period+1) prescaled clock enables, in periodic or one-shot mode. Feeds per-axis step generators.
//   Period updates are shadowed, so a running channel never sees a torn period.
// PARAMETERS
//   WIDTH       24  width of period and count registers
//   CHANNELS     4  number of independent timer channels (>=1)
//   PRESCALE_W   8  width of shared prescaler divide value
// PORTS
//   clk          in   1                   system clock
//   rst          in   1                   reset, asynchronous, active-low
//   prescale     in   PRESCALE_W          shared divider; enable every (prescale+1) clk
//   cfg_we       in   1                   write strobe for channel config
//   cfg_ch       in   max(1,$clog2(CH))   target channel of cfg write
//   cfg_period   in   WIDTH               period value to shadow register
//   cfg_oneshot  in   1                   mode to shadow: 1 one-shot, 0 periodic
//   start        in   CHANNELS            per-channel start/restart strobe
//   stop         in   CHANNELS            per-channel stop strobe
//   tick         out  CHANNELS            one-clk pulse at terminal count
//   busy         out  CHANNELS            channel in RUN state
// BEHAVIOUR
//   - Reset: prescaler count 0, all counts/active/shadow periods 0, mode periodic, state IDLE,
//     tick=0, busy=0. Everything clears mid-operation; no tick after rst deasserts until start.
//   - Prescaler: free-running 0..prescale, ce high in the cycle count==prescale, then wraps to 0.
//     prescale=0 -> ce every clk. prescale changed mid-count: compare uses new value; count>=prescale wraps.
//   - Config: cfg_we stores cfg_period/cfg_oneshot into shadow of channel cfg_ch. cfg_ch>=CHANNELS
//     ignored. Shadow copied to active on start and at every terminal count.
//   - Channel FSM IDLE/RUN:
//     IDLE + start -> RUN; count<=0, active<=shadow, busy<=1.
//     RUN + ce: count>=active -> count<=0, tick<=1 (registered, one clk), active<=shadow;
//       if oneshot -> IDLE, busy<=0 on same edge tick rises. Else count<=count+1.
//     RUN + start (no stop) -> restart: count<=0, active<=shadow, no tick that cycle.
//     stop -> IDLE, count<=0, tick<=0; stop wins over start and over a same-cycle terminal count.
//   - Latency: start edge k, ce every clk, period P -> first tick high after edge k+P+1,
//     then every P+1 clk. Period 0 -> tick on every ce (continuous when prescale=0).
//   - cfg write to a channel on its terminal-count cycle: active takes the OLD shadow; new value
//     applies from the following period. Write + start same cycle: active takes OLD shadow too.
//   - Count is unsigned WIDTH bits; never exceeds active, so no wrap beyond 2^WIDTH-1.
//   - tick never asserted while busy=0 except the final one-shot tick edge.
// STRUCTURE
//   - Package step_timer_pkg: state enum {ST_IDLE, ST_RUN}, CH_IDX_W function (max(1,$clog2(n))).
//   - Sub-module step_timer_channel (FSM, count, active/shadow regs, tick/busy), instantiated
//     CHANNELS times in a generate loop; prescaler and cfg decode inline in the top.
// TESTING
//   1 Reset: assert rst mid-run on ch0 (P=5) -> tick=0, busy=0 immediately; no tick for 20 clk after.
//   2 Periodic: prescale=0, ch0 P=2, start at edge k -> tick at k+3,k+6,k+9; busy stays 1.
//   3 One-shot + prescale: prescale=3, ch1 P=1 oneshot, start -> single tick 8 clk later
//     (first ce alignment aware), busy falls on tick edge, no further ticks in 40 clk.
//   4 Shadow update: ch2 P=4 running, write P=1 mid-period -> current period still 5 clk,
//     subsequent ticks every 2 clk; write on terminal-count cycle -> one more 5-clk period.
//   5 Collisions: stop+start same cycle -> IDLE; stop on terminal cycle -> no tick; restart
//     mid-period -> next tick P+1 clk after restart edge.
//   6 Independence: 4 channels P=0,1,2,3 started together -> tick rates 1,1/2,1/3,1/4 clk;
//     cfg_ch=out-of-range write (CHANNELS=3 build) changes nothing.

Source files
------------

// File: rtl/step_timer_pkg.sv
// step_timer_pkg: shared channel state type and channel-index width helper
package step_timer_pkg;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic int CH_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/step_timer_channel.sv
// step_timer_channel: one interval channel with shadowed period/mode and a registered tick
module step_timer_channel import step_timer_pkg::*; #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             busy
);
  state_t state;
  logic [WIDTH-1:0] count, active, shadow;
  logic oneshot, shadow_oneshot, term;
  assign busy = state == ST_RUN;
  assign term = busy && ce && (count >= active);
  // start and terminal count both reload from the shadow; a same-edge cfg write lands next period
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
      active <= '0;
      shadow <= '0;
      oneshot <= 1'b0;
      shadow_oneshot <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (cfg_we) begin
        shadow <= cfg_period;
        shadow_oneshot <= cfg_oneshot;
      end
      if (stop) begin
        state <= ST_IDLE;
        count <= '0;
      end else if (start || term) begin
        count <= '0;
        active <= shadow;
        oneshot <= shadow_oneshot;
        state <= (start || !oneshot) ? ST_RUN : ST_IDLE;
        tick <= !start;
      end else if (busy && ce) begin
        count <= count + WIDTH'(1);
      end
    end
endmodule

// File: rtl/step_interval_timer.sv
// step_interval_timer: multi-channel programmable interval timer sharing one prescaler
module step_interval_timer import step_timer_pkg::*; #(
  parameter int WIDTH      = 24,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PRESCALE_W-1:0]           prescale,
  input  logic                            cfg_we,
  input  logic [CH_IDX_W(CHANNELS)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]                cfg_period,
  input  logic                            cfg_oneshot,
  input  logic [CHANNELS-1:0]             start,
  input  logic [CHANNELS-1:0]             stop,
  output logic [CHANNELS-1:0]             tick,
  output logic [CHANNELS-1:0]             busy
);
  localparam int CW = CH_IDX_W(CHANNELS);
  logic [PRESCALE_W-1:0] pcount;
  logic ce;
  // >= so a prescale lowered below the running count wraps instead of running to overflow
  assign ce = pcount >= prescale;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pcount <= '0;
    else pcount <= ce ? '0 : pcount + PRESCALE_W'(1);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    step_timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .ce          (ce),
      .cfg_we      (cfg_we && cfg_ch == CW'(i)),
      .cfg_period  (cfg_period),
      .cfg_oneshot (cfg_oneshot),
      .start       (start[i]),
      .stop        (stop[i]),
      .tick        (tick[i]),
      .busy        (busy[i])
    );
  end
endmodule
